// File: rtl/mv_dac_driver.sv
// mv_dac_driver: mV setpoint to 16-bit code, PWM DAC output (define SIGMA_DELTA_EN for a first-order modulator instead)
module mv_dac_driver #(
   parameter int unsigned SCALING_FACTOR = 26844,
   parameter int unsigned SHIFT_FACTOR   = 12,
   parameter int unsigned MV_MAX         = 9999,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mv_valid,
   input  logic [15:0] mv_data,
   output logic        mv_ready,
   output logic [15:0] dac_code,
   output logic        pwm_out,
   output logic        period_start
);
   localparam int PW = 16 + $clog2(SCALING_FACTOR) + 1;
   localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, SHIFT = 2'd2, PEND = 2'd3;
   localparam logic [15:0] mv_max_c = 16'(MV_MAX);
   localparam logic [PW-1:0] scale_c = PW'(SCALING_FACTOR);
   logic [1:0] state;
   logic [15:0] m, code_pend;
   logic [PW-1:0] prod, prod_sh;
   logic [CNT_WIDTH-1:0] counter;
   logic wrap, accept, apply;
   assign mv_ready = (state == IDLE) && !reset;
   assign accept = mv_valid && mv_ready;
   assign wrap = &counter;
   assign prod_sh = prod >> SHIFT_FACTOR;
`ifdef SIGMA_DELTA_EN
   assign apply = state == PEND;
`else
   assign apply = (state == PEND) && wrap;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         m         <= '0;
         prod      <= '0;
         code_pend <= '0;
         dac_code  <= '0;
      end else begin
         if (accept) begin
            m     <= (mv_data > mv_max_c) ? mv_max_c : mv_data;
            state <= MULT;
         end
         if (state == MULT) begin
            prod  <= {{(PW-16){1'b0}}, m} * scale_c;
            state <= SHIFT;
         end
         if (state == SHIFT) begin
            code_pend <= (|prod_sh[PW-1:16]) ? 16'hFFFF : prod_sh[15:0];
            state     <= PEND;
         end
         if (apply) begin
            dac_code <= code_pend;
            state    <= IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         counter      <= '0;
         period_start <= 1'b0;
      end else begin
         counter      <= counter + CNT_WIDTH'(1);
         period_start <= wrap;
      end
   end
`ifdef SIGMA_DELTA_EN
   logic [15:0] acc;
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         pwm_out <= 1'b0;
      end else begin
         {pwm_out, acc} <= {1'b0, acc} + {1'b0, dac_code};
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) pwm_out <= 1'b0;
      else pwm_out <= counter < dac_code[15 -: CNT_WIDTH];
   end
`endif
endmodule

// File: tb/tb_mv_dac_driver.sv
// tb_mv_dac_driver: directed checks of mv_dac_driver with CNT_WIDTH=8 (256-cycle periods)
module tb_mv_dac_driver;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mv_valid = 1'b0;
   logic [15:0] mv_data = '0;
   logic        mv_ready, pwm_out, period_start;
   logic [15:0] dac_code;
   int total = 0, bad = 0;

   mv_dac_driver #(.CNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .mv_valid(mv_valid), .mv_data(mv_data),
      .mv_ready(mv_ready), .dac_code(dac_code), .pwm_out(pwm_out), .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_start();
      int n = 0;
      step();
      while (!period_start && n < 300) begin
         step();
         n++;
      end
      if (!period_start) chk("start_timeout", {31'b0, period_start}, 1);
   endtask

   // off = cycles after counter 0 at which the setpoint is presented
   task automatic send_at(input string tag, input int off, input logic [15:0] mv,
                          input logic [15:0] exp, input int exp_wait);
      int n;
      wait_start();
      repeat (off) step();
      chk({tag, "_rdy"}, {31'b0, mv_ready}, 1);
      mv_valid = 1'b1;
      mv_data = mv;
      step();
      mv_valid = 1'b0;
      mv_data = 16'hDEAD;
      n = 1;
      while (!mv_ready && n < 600) begin
         step();
         n++;
      end
      chk({tag, "_wait"}, n, exp_wait);
      chk({tag, "_code"}, {16'b0, dac_code}, {16'b0, exp});
      chk({tag, "_ps"}, {31'b0, period_start}, 1);
   endtask

   task automatic count_period(output int ones, output int starts);
      ones = 0;
      starts = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         ones += int'(pwm_out);
         starts += int'(period_start);
      end
   endtask

   initial begin
      int ones, starts, nz, rdy_hi, odd_upd;
      logic [15:0] prev;
      repeat (3) step();
      chk("rst_ready", {31'b0, mv_ready}, 0);
      chk("rst_code", {16'b0, dac_code}, 0);
      chk("rst_pwm", {31'b0, pwm_out}, 0);
      chk("rst_ps", {31'b0, period_start}, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", {31'b0, mv_ready}, 1);
      ones = 0; starts = 0; nz = 0;
      for (int i = 0; i < 512; i++) begin
         step();
         ones += int'(pwm_out);
         starts += int'(period_start);
         nz += int'(dac_code != 0);
      end
      chk("idle_ones", ones, 0);
      chk("idle_starts", starts, 2);
      chk("idle_code", nz, 0);

      send_at("t2", 0, 16'd5000, 16'd32768, 256);
      count_period(ones, starts);
      chk("t2_ones", ones, 128);
      chk("t2_starts", starts, 1);

      send_at("t3a", 10, 16'd9999, 16'd65530, 246);
      count_period(ones, starts);
      chk("t3a_ones", ones, 255);
      send_at("t3b", 253, 16'd12000, 16'd65530, 259);
      count_period(ones, starts);
      chk("t3b_ones", ones, 255);
      send_at("pend_wrap", 252, 16'd2000, 16'd13107, 4);

      // held mv_valid: 1000 mV, then 0 mV accepted only after the first apply
      wait_start();
      mv_valid = 1'b1;
      mv_data = 16'd1000;
      rdy_hi = 0; odd_upd = 0; ones = 0;
      prev = dac_code;
      for (int i = 1; i <= 512; i++) begin
         step();
         if (i == 1) mv_data = 16'd0;
         if (dac_code != prev && !period_start) odd_upd++;
         prev = dac_code;
         if (i > 256) ones += int'(pwm_out);
         if (i == 256) begin
            chk("t4_code1", {16'b0, dac_code}, 6553);
            chk("t4_rdy1", {31'b0, mv_ready}, 1);
         end else if (i == 512) begin
            chk("t4_code2", {16'b0, dac_code}, 0);
            chk("t4_rdy2", {31'b0, mv_ready}, 1);
            mv_valid = 1'b0;
         end else begin
            rdy_hi += int'(mv_ready);
         end
      end
      chk("t4_rdy_low", rdy_hi, 0);
      chk("t4_odd_upd", odd_upd, 0);
      chk("t4_ones", ones, 25);

      // reset while pending discards the setpoint
      wait_start();
      mv_valid = 1'b1;
      mv_data = 16'd5000;
      step();
      mv_valid = 1'b0;
      repeat (9) step();
      chk("t5_busy", {31'b0, mv_ready}, 0);
      reset = 1'b1;
      repeat (3) step();
      chk("t5_rst_ready", {31'b0, mv_ready}, 0);
      chk("t5_rst_code", {16'b0, dac_code}, 0);
      reset = 1'b0;
      nz = 0; ones = 0;
      for (int i = 0; i < 600; i++) begin
         step();
         nz += int'(dac_code != 0);
         ones += int'(pwm_out);
      end
      chk("t5_code", nz, 0);
      chk("t5_ones", ones, 0);
      chk("t5_ready", {31'b0, mv_ready}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
